// File: rtl/tc_scan_scheduler.sv
// tc_scan_scheduler: round-robin poll scheduler sharing one SPI master
// between NCH thermocouple converter chips. After a power-up settle time it
// polls each enabled channel in turn, decodes the 32-bit frame and presents
// one result per completed transfer.
//
// Handshake: spi_ena is a level request held while in REQ; the SPI master
// acknowledges by dropping spi_not_busy, and completion is seen when
// spi_not_busy returns high. rd_valid is a one-cycle strobe with no
// backpressure; the result fields stay stable until the next capture.
module tc_scan_scheduler #(
    parameter int NCH         = 4,
    parameter int CHW         = 2,
    parameter int STARTUP_CYC = 2400,
    parameter int GAP_CYC     = 800,
    parameter int TIMEOUT_CYC = 4000,
    parameter int CBITS       = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   chan_en,
    input  logic             spi_not_busy,
    input  logic [31:0]      spi_rx_data,
    output logic             spi_ena,
    output logic [CHW-1:0]   spi_cs_sel,
    output logic             rd_valid,
    output logic [CHW-1:0]   rd_chan,
    output logic [13:0]      tc_temp,
    output logic [11:0]      junction_temp,
    output logic [3:0]       fault_bits,
    output logic [NCH-1:0]   fault_sticky,
    output logic             timeout_err,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_STARTUP = 3'd0,
        S_SELECT  = 3'd1,
        S_REQ     = 3'd2,
        S_BUSY    = 3'd3,
        S_CAPTURE = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    localparam logic [CBITS-1:0] L_START_LAST = CBITS'(STARTUP_CYC - 1);
    localparam logic [CBITS-1:0] L_GAP_LAST   = CBITS'(GAP_CYC - 1);
    localparam logic [CBITS-1:0] L_TO_LAST    = CBITS'(TIMEOUT_CYC - 1);
    localparam logic [CHW-1:0]   L_LAST_INIT  = CHW'(NCH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CBITS-1:0] r_cnt;
    logic [CBITS-1:0] w_cnt_nxt;
    logic [CHW-1:0]   r_last_chan;
    logic [CHW-1:0]   r_cs_sel;
    logic             r_spi_ena;
    logic             r_rd_valid;
    logic [CHW-1:0]   r_rd_chan;
    logic [13:0]      r_tc_temp;
    logic [11:0]      r_junction_temp;
    logic [3:0]       r_fault_bits;
    logic [NCH-1:0]   r_fault_sticky;
    logic             r_timeout_err;
    logic             w_timeout;
    logic             w_sel_found;
    logic [CHW-1:0]   w_sel_idx;
    logic [3:0]       w_frame_fault;
    logic             w_unused_bits;

    assign w_frame_fault = {spi_rx_data[16], spi_rx_data[2:0]};
    // Frame bits 17 and 3 carry no information for this block.
    assign w_unused_bits = ^{spi_rx_data[17], spi_rx_data[3]};

    // Round-robin search starting after last_chan; last_chan itself is
    // visited last. Iterating from the far end keeps the nearest hit.
    always_comb begin
        w_sel_found = |chan_en;
        w_sel_idx   = '0;
        for (int k = NCH; k >= 1; k--) begin
            int w_idx;
            w_idx = (int'(r_last_chan) + k) % NCH;
            if (chan_en[w_idx]) begin
                w_sel_idx = w_idx[CHW-1:0];
            end
        end
    end

    // Next-state and shared counter; one counter serves STARTUP, REQ+BUSY
    // (timeout) and GAP because those phases never overlap.
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_timeout = 1'b0;
        case (r_state)
            S_STARTUP: begin
                if (r_cnt == L_START_LAST) begin
                    w_cnt_nxt = '0;
                    w_next    = S_SELECT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_SELECT: begin
                w_cnt_nxt = '0;
                if (w_sel_found) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (r_cnt == L_TO_LAST) begin
                    w_timeout = 1'b1;
                    w_cnt_nxt = '0;
                    w_next    = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (!spi_not_busy) begin
                        w_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == L_TO_LAST) begin
                    w_timeout = 1'b1;
                    w_cnt_nxt = '0;
                    w_next    = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (spi_not_busy) begin
                        w_next = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                w_cnt_nxt = '0;
                w_next    = S_GAP;
            end
            S_GAP: begin
                if (r_cnt == L_GAP_LAST) begin
                    w_cnt_nxt = '0;
                    w_next    = S_SELECT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt = '0;
                w_next    = S_SELECT;
            end
        endcase
    end

    // State, counter and channel bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_STARTUP;
            r_cnt       <= '0;
            r_last_chan <= L_LAST_INIT;
            r_cs_sel    <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_SELECT && w_sel_found) begin
                r_cs_sel    <= w_sel_idx;
                r_last_chan <= w_sel_idx;
            end
        end
    end

    // Registered request and timeout strobe, derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_spi_ena     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_spi_ena     <= (w_next == S_REQ);
            r_timeout_err <= w_timeout;
        end
    end

    // Result capture; fields hold until the next completed transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid      <= 1'b0;
            r_rd_chan       <= '0;
            r_tc_temp       <= '0;
            r_junction_temp <= '0;
            r_fault_bits    <= '0;
            r_fault_sticky  <= '0;
        end else begin
            r_rd_valid <= (r_state == S_CAPTURE);
            if (r_state == S_CAPTURE) begin
                r_rd_chan       <= r_cs_sel;
                r_tc_temp       <= spi_rx_data[31:18];
                r_junction_temp <= spi_rx_data[15:4];
                r_fault_bits    <= w_frame_fault;
                if (w_frame_fault != 4'd0) begin
                    r_fault_sticky[r_cs_sel] <= 1'b1;
                end
            end
        end
    end

    assign spi_ena       = r_spi_ena;
    assign spi_cs_sel    = r_cs_sel;
    assign rd_valid      = r_rd_valid;
    assign rd_chan       = r_rd_chan;
    assign tc_temp       = r_tc_temp;
    assign junction_temp = r_junction_temp;
    assign fault_bits    = r_fault_bits;
    assign fault_sticky  = r_fault_sticky;
    assign timeout_err   = r_timeout_err;
    assign dbg_state     = r_state;

endmodule
